// File: rtl/alu8_pkg.sv
// ---------------------------------------------------------------------------
// alu8_pkg
// Shared constants for the 8-bit ALU sequencer:
//   - MIPS-style 4-bit ALU op codes (OP_AND .. OP_NOR)
//   - sequencer command codes (CMD_ALU, CMD_MUL, CMD_DIV, CMD_RSV)
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu8_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] CMD_ALU = 2'b00;
   localparam logic [1:0] CMD_MUL = 2'b01;
   localparam logic [1:0] CMD_DIV = 2'b10;
   localparam logic [1:0] CMD_RSV = 2'b11;

   // ST_WB is the single write-back cycle that moves the iteration registers
   // (or the divide-by-zero / reserved-cmd constants) into the result regs.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_EXEC = 3'd2,
      ST_MUL  = 3'd3,
      ST_DIV  = 3'd4,
      ST_WB   = 3'd5,
      ST_DONE = 3'd6
   } state_t;

endpackage

// File: rtl/alu8_iter_dp.sv
// ---------------------------------------------------------------------------
// alu8_iter_dp
// Iteration datapath shared by the shift-add multiply and the restoring
// divide. Holds P_hi/P_lo/M and the iteration counter.
//   MUL : P_hi = partial product high, P_lo = multiplier / product low, M = B
//   DIV : P_hi = remainder R,          P_lo = quotient Q,              M = D
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_init                  load M=i_b, P_hi=0, P_lo=i_a, cnt=0
//   i_a, i_b                operands for i_init
//   i_step_mul, i_step_div  perform one MUL / DIV iteration this cycle
//   i_alu_res, i_alu_cout   ALU result / carry for the current iteration
//   o_p_hi, o_p_lo, o_m     register contents
//   o_div_r                 R' = low bits of ({R,Q} << 1), the DIV ALU operand
//   o_last                  counter at its final iteration
// ---------------------------------------------------------------------------
module alu8_iter_dp #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_init,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step_mul,
   input  logic             i_step_div,
   input  logic [WIDTH-1:0] i_alu_res,
   input  logic             i_alu_cout,
   output logic [WIDTH-1:0] o_p_hi,
   output logic [WIDTH-1:0] o_p_lo,
   output logic [WIDTH-1:0] o_m,
   output logic [WIDTH-1:0] o_div_r,
   output logic             o_last
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_p_hi;
   logic [WIDTH-1:0] r_p_lo;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_cnt;

   logic             w_div_msb;
   logic [WIDTH-1:0] w_div_r;
   logic             w_div_take;

   // {msb, R', Q'} = {R, Q} << 1; msb is the 9th bit of the remainder path.
   assign w_div_msb  = r_p_hi[WIDTH-1];
   assign w_div_r    = {r_p_hi[WIDTH-2:0], r_p_lo[WIDTH-1]};
   // Subtract succeeds when the shifted remainder overflowed 8 bits or the
   // ALU reports no borrow (cout=1).
   assign w_div_take = w_div_msb | i_alu_cout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_p_hi <= '0;
         r_p_lo <= '0;
         r_m    <= '0;
         r_cnt  <= '0;
      end else if (i_init) begin
         r_m    <= i_b;
         r_p_hi <= '0;
         r_p_lo <= i_a;
         r_cnt  <= '0;
      end else if (i_step_mul) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_p_lo[0])
            {r_p_hi, r_p_lo} <= {i_alu_cout, i_alu_res, r_p_lo[WIDTH-1:1]};
         else
            {r_p_hi, r_p_lo} <= {1'b0, r_p_hi, r_p_lo[WIDTH-1:1]};
      end else if (i_step_div) begin
         r_cnt  <= r_cnt + 1'b1;
         r_p_hi <= w_div_take ? i_alu_res : w_div_r;
         r_p_lo <= {r_p_lo[WIDTH-2:0], w_div_take};
      end
   end

   assign o_p_hi  = r_p_hi;
   assign o_p_lo  = r_p_lo;
   assign o_m     = r_m;
   assign o_div_r = w_div_r;
   assign o_last  = (r_cnt == CNT_LAST);

endmodule

// File: rtl/alu8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu8_seq_ctrl
// Multi-cycle sequencer that owns an external combinational 8-bit ALU.
// Runs a single ALU op, an 8x8 unsigned shift-add multiply or an 8/8
// unsigned restoring divide, one ALU pass per cycle.
// Latency from the accepting edge: ALU op / div-by-zero / reserved cmd = 3,
// MUL / DIV = 11 (LOAD, 8 iterations, write-back, DONE).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_cmd, i_op_in      command strobe, command, ALU op (cmd=00)
//   i_a_in, i_b_in               operands, sampled when start is accepted
//   o_busy, o_done, o_err        status; done is a 1-cycle pulse
//   o_res_hi, o_res_lo           results (MUL product, DIV rem/quot, ALU res)
//   o_flag_z/c/v                 ALU flags (ALU op only)
//   o_alu_a, o_alu_b, o_alu_op   ALU drive
//   i_alu_res, i_alu_cout, i_alu_zero, i_alu_ovf  ALU observe
// ---------------------------------------------------------------------------
module alu8_seq_ctrl
   import alu8_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] DIV0_Q = 8'hFF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_cmd,
   input  logic [3:0]       i_op_in,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic [WIDTH-1:0] i_b_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_res_hi,
   output logic [WIDTH-1:0] o_res_lo,
   output logic             o_flag_z,
   output logic             o_flag_c,
   output logic             o_flag_v,
   output logic             o_err,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [3:0]       o_alu_op,
   input  logic [WIDTH-1:0] i_alu_res,
   input  logic             i_alu_cout,
   input  logic             i_alu_zero,
   input  logic             i_alu_ovf
);

   state_t r_state, w_next;

   logic [WIDTH-1:0] r_a, r_b;
   logic [3:0]       r_op;
   logic [1:0]       r_cmd;
   logic [WIDTH-1:0] r_res_hi, r_res_lo;
   logic             r_flag_z, r_flag_c, r_flag_v, r_err;

   logic             w_accept;
   logic             w_b_zero;
   logic [WIDTH-1:0] w_p_hi, w_p_lo, w_m, w_div_r;
   logic             w_last;

   assign w_accept = (r_state == ST_IDLE) && i_start;
   assign w_b_zero = (r_b == '0);

   alu8_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_init     (r_state == ST_LOAD),
      .i_a        (r_a),
      .i_b        (r_b),
      .i_step_mul (r_state == ST_MUL),
      .i_step_div (r_state == ST_DIV),
      .i_alu_res  (i_alu_res),
      .i_alu_cout (i_alu_cout),
      .o_p_hi     (w_p_hi),
      .o_p_lo     (w_p_lo),
      .o_m        (w_m),
      .o_div_r    (w_div_r),
      .o_last     (w_last)
   );

   // ---- FSM: state register ----
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_next = ST_LOAD;
         ST_LOAD: begin
            case (r_cmd)
               CMD_ALU: w_next = ST_EXEC;
               CMD_MUL: w_next = ST_MUL;
               // Divide-by-zero skips the iterations entirely.
               CMD_DIV: w_next = w_b_zero ? ST_WB : ST_DIV;
               default: w_next = ST_WB;
            endcase
         end
         ST_EXEC: w_next = ST_DONE;
         ST_MUL:  if (w_last) w_next = ST_WB;
         ST_DIV:  if (w_last) w_next = ST_WB;
         ST_WB:   w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      o_busy   = 1'b0;
      o_done   = 1'b0;
      o_alu_a  = '0;
      o_alu_b  = '0;
      o_alu_op = 4'b0000;
      case (r_state)
         ST_LOAD: o_busy = 1'b1;
         ST_EXEC: begin
            o_busy   = 1'b1;
            o_alu_a  = r_a;
            o_alu_b  = r_b;
            o_alu_op = r_op;
         end
         ST_MUL: begin
            o_busy   = 1'b1;
            o_alu_a  = w_p_hi;
            o_alu_b  = w_m;
            o_alu_op = OP_ADD;
         end
         ST_DIV: begin
            o_busy   = 1'b1;
            o_alu_a  = w_div_r;
            o_alu_b  = w_m;
            o_alu_op = OP_SUB;
         end
         ST_WB:   o_busy = 1'b1;
         ST_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   // ---- command latch and result registers ----
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cmd    <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_v <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         // Results of the previous command stay visible until this point.
         r_a      <= i_a_in;
         r_b      <= i_b_in;
         r_op     <= i_op_in;
         r_cmd    <= i_cmd;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_v <= 1'b0;
         r_err    <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         r_res_lo <= i_alu_res;
         r_flag_z <= i_alu_zero;
         r_flag_c <= i_alu_cout;
         r_flag_v <= i_alu_ovf;
      end else if (r_state == ST_WB) begin
         case (r_cmd)
            CMD_MUL: begin
               r_res_hi <= w_p_hi;
               r_res_lo <= w_p_lo;
            end
            CMD_DIV: begin
               if (w_b_zero) begin
                  r_res_hi <= r_a;
                  r_res_lo <= DIV0_Q;
                  r_err    <= 1'b1;
               end else begin
                  r_res_hi <= w_p_hi;
                  r_res_lo <= w_p_lo;
               end
            end
            CMD_RSV: r_err <= 1'b1;
            default: ;
         endcase
      end
   end

   assign o_res_hi = r_res_hi;
   assign o_res_lo = r_res_lo;
   assign o_flag_z = r_flag_z;
   assign o_flag_c = r_flag_c;
   assign o_flag_v = r_flag_v;
   assign o_err    = r_err;

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
module tb_alu8_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [3:0] op_in = 4'b0000;
   logic [7:0] a_in = 8'h00, b_in = 8'h00;
   logic       busy, done, flag_z, flag_c, flag_v, err;
   logic [7:0] res_hi, res_lo, alu_a, alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_res;
   logic       alu_cout, alu_zero, alu_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Reference combinational ALU (the external ALU this block drives).
   always_comb begin
      logic [8:0] t;
      t        = 9'd0;
      alu_res  = 8'h00;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_op)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: begin
            t = {1'b0, alu_a} + {1'b0, alu_b};
            alu_res = t[7:0]; alu_cout = t[8];
            alu_ovf = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
         end
         4'b0110: begin
            t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            alu_res = t[7:0]; alu_cout = t[8];
            alu_ovf = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
         end
         4'b0111: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
         4'b1100: alu_res = ~(alu_a | alu_b);
         default: alu_res = 8'h00;
      endcase
      alu_zero = (alu_res == 8'h00);
   end

   alu8_seq_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_cmd(cmd), .i_op_in(op_in),
      .i_a_in(a_in), .i_b_in(b_in), .o_busy(busy), .o_done(done),
      .o_res_hi(res_hi), .o_res_lo(res_lo), .o_flag_z(flag_z), .o_flag_c(flag_c),
      .o_flag_v(flag_v), .o_err(err), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .o_alu_op(alu_op), .i_alu_res(alu_res), .i_alu_cout(alu_cout),
      .i_alu_zero(alu_zero), .i_alu_ovf(alu_ovf)
   );

   // Issue one command from IDLE; returns done latency (cycles after the
   // accepting edge, -1 on timeout), busy cycle count and whether done was
   // still high one cycle later. Ends in IDLE with results held.
   task automatic run_cmd(input logic [1:0] c, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int nbusy, output logic dn_after);
      int k;
      start = 1'b1; cmd = c; op_in = op; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0; a_in = 8'hA5; b_in = 8'h5A; op_in = 4'b1111;
      k = 1; nbusy = 0;
      while (done !== 1'b1 && k < 40) begin
         if (busy === 1'b1) nbusy++;
         @(posedge clk); #1;
         k++;
      end
      lat = (done === 1'b1) ? k : -1;
      @(posedge clk); #1;
      dn_after = done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
      total++; if ({res_hi, res_lo} !== 16'h0000) begin bad++; $display("FAIL reset_res got %h want 0000", {res_hi, res_lo}); end
      total++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {flag_z, flag_c, flag_v}); end
      total++; if ({alu_a, alu_b, alu_op} !== 20'h0) begin bad++; $display("FAIL reset_alu_drive got %h want 0", {alu_a, alu_b, alu_op}); end
   endtask

   task automatic test_mul();
      int lat, nb; logic da;
      run_cmd(2'b01, 4'b0000, 8'd13, 8'd11, lat, nb, da);
      total++; if (lat !== 11) begin bad++; $display("FAIL mul13_latency got %0d want 11", lat); end
      total++; if (nb !== 10) begin bad++; $display("FAIL mul13_busy got %0d want 10", nb); end
      total++; if ({res_hi, res_lo} !== 16'h008F) begin bad++; $display("FAIL mul13_prod got %h want 008f", {res_hi, res_lo}); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL mul13_err got %b want 0", err); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL mul13_done_pulse got %b want 0", da); end
      total++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin bad++; $display("FAIL mul13_flags got %b want 000", {flag_z, flag_c, flag_v}); end
      run_cmd(2'b01, 4'b0000, 8'd255, 8'd255, lat, nb, da);
      total++; if ({res_hi, res_lo} !== 16'hFE01) begin bad++; $display("FAIL mul255_prod got %h want fe01", {res_hi, res_lo}); end
      total++; if (lat !== 11) begin bad++; $display("FAIL mul255_latency got %0d want 11", lat); end
   endtask

   task automatic test_div();
      int lat, nb; logic da;
      run_cmd(2'b10, 4'b0000, 8'd200, 8'd7, lat, nb, da);
      total++; if (lat !== 11) begin bad++; $display("FAIL div200_latency got %0d want 11", lat); end
      total++; if (res_lo !== 8'd28) begin bad++; $display("FAIL div200_quot got %0d want 28", res_lo); end
      total++; if (res_hi !== 8'd4) begin bad++; $display("FAIL div200_rem got %0d want 4", res_hi); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL div200_err got %b want 0", err); end
      run_cmd(2'b10, 4'b0000, 8'd255, 8'd1, lat, nb, da);
      total++; if ({res_hi, res_lo} !== 16'h00FF) begin bad++; $display("FAIL div255_res got %h want 00ff", {res_hi, res_lo}); end
   endtask

   task automatic test_div0();
      int lat, nb; logic da;
      run_cmd(2'b10, 4'b0000, 8'd9, 8'd0, lat, nb, da);
      total++; if (lat !== 3) begin bad++; $display("FAIL div0_latency got %0d want 3", lat); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL div0_err got %b want 1", err); end
      total++; if (res_lo !== 8'hFF) begin bad++; $display("FAIL div0_quot got %h want ff", res_lo); end
      total++; if (res_hi !== 8'd9) begin bad++; $display("FAIL div0_rem got %0d want 9", res_hi); end
   endtask

   task automatic test_alu();
      int lat, nb; logic da;
      run_cmd(2'b00, 4'b0110, 8'd5, 8'd5, lat, nb, da);
      total++; if (lat !== 3) begin bad++; $display("FAIL sub_latency got %0d want 3", lat); end
      total++; if (res_lo !== 8'd0) begin bad++; $display("FAIL sub_res got %0d want 0", res_lo); end
      total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL sub_z got %b want 1", flag_z); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL sub_err_cleared got %b want 0", err); end
      run_cmd(2'b00, 4'b0010, 8'd200, 8'd100, lat, nb, da);
      total++; if (res_lo !== 8'd44) begin bad++; $display("FAIL add_res got %0d want 44", res_lo); end
      total++; if ({flag_z, flag_c, flag_v} !== 3'b010) begin bad++; $display("FAIL add_flags got %b want 010", {flag_z, flag_c, flag_v}); end
      total++; if (res_hi !== 8'd0) begin bad++; $display("FAIL add_hi got %0d want 0", res_hi); end
      run_cmd(2'b00, 4'b0000, 8'hF0, 8'h3C, lat, nb, da);
      total++; if (res_lo !== 8'h30) begin bad++; $display("FAIL and_res got %h want 30", res_lo); end
      run_cmd(2'b00, 4'b0111, 8'hFF, 8'h01, lat, nb, da);
      total++; if (res_lo !== 8'h01) begin bad++; $display("FAIL slt_res got %h want 01", res_lo); end
   endtask

   task automatic test_rsv();
      int lat, nb; logic da;
      run_cmd(2'b11, 4'b0010, 8'd7, 8'd3, lat, nb, da);
      total++; if (lat !== 3) begin bad++; $display("FAIL rsv_latency got %0d want 3", lat); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL rsv_err got %b want 1", err); end
      total++; if ({res_hi, res_lo} !== 16'h0000) begin bad++; $display("FAIL rsv_res got %h want 0000", {res_hi, res_lo}); end
   endtask

   // start pulsed while busy and again during done must both be dropped.
   task automatic test_back_to_back();
      int k, ndone;
      start = 1'b1; cmd = 2'b01; a_in = 8'd13; b_in = 8'd11;
      @(posedge clk); #1;
      start = 1'b0;
      k = 1;
      while (done !== 1'b1 && k < 40) begin
         if (k == 3) begin start = 1'b1; cmd = 2'b10; a_in = 8'd200; b_in = 8'd7; end
         else start = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      total++; if (done !== 1'b1 || k !== 11) begin bad++; $display("FAIL b2b_latency got %0d want 11", k); end
      total++; if ({res_hi, res_lo} !== 16'h008F) begin bad++; $display("FAIL b2b_prod got %h want 008f", {res_hi, res_lo}); end
      start = 1'b1; cmd = 2'b10; a_in = 8'd200; b_in = 8'd7;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1 || busy === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL b2b_ignored_start got %0d active cycles want 0", ndone); end
   endtask

   task automatic test_rst_abort();
      int k, ndone, lat, nb; logic da;
      start = 1'b1; cmd = 2'b01; a_in = 8'd200; b_in = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (k = 1; k < 6; k++) begin
         start = (k == 3);
         @(posedge clk); #1;
      end
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got %b want 1", busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL abort_status got %b want 000", {busy, done, err}); end
      total++; if ({res_hi, res_lo} !== 16'h0000) begin bad++; $display("FAIL abort_res got %h want 0000", {res_hi, res_lo}); end
      total++; if ({alu_a, alu_b, alu_op} !== 20'h0) begin bad++; $display("FAIL abort_alu_drive got %h want 0", {alu_a, alu_b, alu_op}); end
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", ndone); end
      run_cmd(2'b01, 4'b0000, 8'd3, 8'd4, lat, nb, da);
      total++; if ({res_hi, res_lo} !== 16'd12 || lat !== 11) begin bad++; $display("FAIL abort_mul3x4 got %h lat %0d want 000c lat 11", {res_hi, res_lo}, lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div0();
      test_alu();
      test_rsv();
      test_back_to_back();
      test_rst_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
